result_streamer: RTL and testbench
==================================

RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 The block SHALL have parameter HDR_BYTE, default 8'h02, header byte value (matrix dimension code).
REQ-002 The block SHALL have parameter ELEM_W, default 16, result element width; the payload is 4 elements of a 2x2 result, 64 bits.
REQ-003 The block SHALL have the port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have the port res_mat  input  64  product matrix from the multiplier, {r00,r01,r10,r11} with r00 in [63:48].
REQ-006 The block SHALL have the port res_valid  input  1  one-cycle pulse; res_mat is valid in that cycle.
REQ-007 The block SHALL have the port out_ready  input  1  downstream can accept a byte this cycle.
REQ-008 The block SHALL have the port data_out  output  8  streamed byte.
REQ-009 The block SHALL have the port ctrl_out  output  2  framing code: 2 = header, 0 = payload, 1 = checksum.
REQ-010 The block SHALL have the port out_valid  output  1  data_out and ctrl_out hold a beat.
REQ-011 The block SHALL have the port busy  output  1  high whenever state is not IDLE.
REQ-012 The block SHALL have the port overflow  output  1  sticky flag; a result was dropped.
REQ-013 The block SHALL have the port frame_cnt  output  8  count of completed frames, wrapping 255 -> 0.

Function
REQ-014 The block SHALL implement the states IDLE, HDR, PAY and CSUM, plus a 3-bit byte index and a 64-bit active register.
REQ-015 The block SHALL transfer a beat on a rising edge where out_valid=1 and out_ready=1; data_out, ctrl_out and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 A frame SHALL be HDR (HDR_BYTE, ctrl 2), then PAY (8 bytes of the active register MSB-first, ctrl 0), then CSUM (XOR of the 8 payload bytes, ctrl 1).
REQ-017 In IDLE, res_valid=1 SHALL load res_mat into the active register, and out_valid SHALL assert with the header on the next cycle (latency 1).
REQ-018 A HDR transfer SHALL go to PAY with index 0; a PAY transfer SHALL increment the index; the transfer at index 7 SHALL go to CSUM.
REQ-019 A CSUM transfer SHALL increment frame_cnt; the block SHALL then go to HDR loading the pending entry if one is held, otherwise to IDLE with out_valid=0.
REQ-020 The block SHALL hold one pending entry: res_valid while busy with pending empty SHALL capture res_mat into pending.
REQ-021 res_valid while busy with pending full SHALL drop the new result and set overflow; the active frame and pending entry SHALL remain unchanged.
REQ-022 res_valid on the cycle of a CSUM transfer with pending empty SHALL load the new result into the active register directly and go to HDR with no IDLE cycle.
REQ-023 res_valid on the cycle of a CSUM transfer with pending full SHALL move pending into the active register and capture the new result into pending, with no drop.
REQ-024 The checksum SHALL accumulate during PAY transfers and be cleared on entry to HDR.
REQ-025 out_ready SHALL be ignored when out_valid=0.

Reset
REQ-026 When RST=1 at a rising edge, the block SHALL go to IDLE with data_out=0, ctrl_out=0, out_valid=0, busy=0, overflow=0, frame_cnt=0, pending empty and the checksum cleared.
REQ-027 Reset mid-frame SHALL abort the frame without completing it; frame_cnt SHALL not increment, and res_valid in the reset cycle SHALL be ignored.

Verification
REQ-028 Scenario: res_mat=64'h0001_0002_0003_0004, out_ready=1 -> bytes 02,00,01,00,02,00,03,00,04,04 with ctrl 2,0x8,1 on 10 consecutive cycles starting 1 cycle after the pulse; frame_cnt=1.
REQ-029 Scenario: same frame, out_ready toggled 1,0,1,0 -> beats held stable while stalled, identical byte sequence, completes in 19 cycles.
REQ-030 Scenario: three pulses A, B, C during frame A with out_ready=1 -> B is streamed back-to-back after A, C is dropped, overflow=1, frame_cnt=2.
REQ-031 Scenario: pulse coincident with the CSUM transfer and pending empty -> the next cycle is the HDR beat of the new frame, busy stays 1.
REQ-032 Scenario: RST during PAY byte 4 -> next cycle out_valid=0, busy=0; a new pulse then produces a complete frame and frame_cnt=1.
REQ-033 Scenario: 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/result_streamer_if.sv
// Bundles the result input, the byte-stream output handshake and status flags.
// The streamer itself is the master; the environment connects to the slave side.
interface result_streamer_if #(
  parameter int MAT_W = 64
);

  logic [MAT_W-1:0] res_mat;
  logic             res_valid;
  logic             out_ready;
  logic [7:0]       data_out;
  logic [1:0]       ctrl_out;
  logic             out_valid;
  logic             busy;
  logic             overflow;
  logic [7:0]       frame_cnt;

  modport master (
    input  res_mat,
    input  res_valid,
    input  out_ready,
    output data_out,
    output ctrl_out,
    output out_valid,
    output busy,
    output overflow,
    output frame_cnt
  );

  modport slave (
    output res_mat,
    output res_valid,
    output out_ready,
    input  data_out,
    input  ctrl_out,
    input  out_valid,
    input  busy,
    input  overflow,
    input  frame_cnt
  );

endinterface

// File: rtl/result_streamer.sv
// Streams each 2x2 result as a framed byte sequence: header, MSB-first payload
// bytes, then an XOR checksum. One further result can wait while a frame is in flight.
module result_streamer #(
  parameter logic [7:0] HDR_BYTE = 8'h02,
  parameter int         ELEM_W   = 16
) (
  input logic              CLK,
  input logic              RST,
  result_streamer_if.master bus
);

  localparam int MAT_W  = 4 * ELEM_W;
  localparam int NBYTES = MAT_W / 8;
  localparam int IDX_W  = $clog2(NBYTES);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [1:0]       CTRL_HDR  = 2'd2;
  localparam logic [1:0]       CTRL_PAY  = 2'd0;
  localparam logic [1:0]       CTRL_CSUM = 2'd1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    CSUM
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [MAT_W-1:0] active;
  logic [MAT_W-1:0] active_next;
  logic [MAT_W-1:0] pending;
  logic [MAT_W-1:0] pending_next;
  logic             pend_full;
  logic             pend_full_next;
  logic [7:0]       csum;
  logic [7:0]       csum_next;
  logic             overflow;
  logic             overflow_next;
  logic [7:0]       frame_cnt;
  logic [7:0]       frame_cnt_next;

  logic             beat_valid;
  logic             xfer;
  logic             csum_xfer;
  logic [MAT_W-1:0] shifted;
  logic [7:0]       cur_byte;

  assign beat_valid = (state != IDLE);
  assign xfer       = beat_valid & bus.out_ready;
  assign csum_xfer  = (state == CSUM) & xfer;

  // The current payload byte is the top byte after shifting out the bytes already sent.
  assign shifted  = active << {idx, 3'b000};
  assign cur_byte = shifted[MAT_W-1 -: 8];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      csum      <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      active    <= active_next;
      pending   <= pending_next;
      pend_full <= pend_full_next;
      csum      <= csum_next;
      overflow  <= overflow_next;
      frame_cnt <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    active_next    = active;
    pending_next   = pending;
    pend_full_next = pend_full;
    csum_next      = csum;
    overflow_next  = overflow;
    frame_cnt_next = frame_cnt;

    case (state)
      IDLE: begin
        if (bus.res_valid) begin
          active_next = bus.res_mat;
          csum_next   = '0;
          state_next  = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          idx_next   = '0;
          state_next = PAY;
        end
      end
      PAY: begin
        if (xfer) begin
          csum_next = csum ^ cur_byte;
          idx_next  = idx + 1'b1;
          if (idx == LAST_IDX) begin
            state_next = CSUM;
          end
        end
      end
      CSUM: begin
        // Finishing a frame chains straight into the next one when a result is waiting.
        if (xfer) begin
          frame_cnt_next = frame_cnt + 8'd1;
          csum_next      = '0;
          if (pend_full) begin
            active_next = pending;
            state_next  = HDR;
            if (bus.res_valid) begin
              pending_next = bus.res_mat;
            end else begin
              pend_full_next = 1'b0;
            end
          end else if (bus.res_valid) begin
            active_next = bus.res_mat;
            state_next  = HDR;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (beat_valid && !csum_xfer && bus.res_valid) begin
      if (!pend_full) begin
        pending_next   = bus.res_mat;
        pend_full_next = 1'b1;
      end else begin
        overflow_next = 1'b1;
      end
    end
  end

  always_comb begin
    bus.data_out = 8'h00;
    bus.ctrl_out = CTRL_PAY;
    case (state)
      HDR: begin
        bus.data_out = HDR_BYTE;
        bus.ctrl_out = CTRL_HDR;
      end
      PAY: begin
        bus.data_out = cur_byte;
        bus.ctrl_out = CTRL_PAY;
      end
      CSUM: begin
        bus.data_out = csum;
        bus.ctrl_out = CTRL_CSUM;
      end
      default: begin
        bus.data_out = 8'h00;
        bus.ctrl_out = CTRL_PAY;
      end
    endcase
  end

  assign bus.out_valid = beat_valid;
  assign bus.busy      = beat_valid;
  assign bus.overflow  = overflow;
  assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_result_streamer.sv
// Scoreboard bench for result_streamer: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares every beat the DUT transfers.
module tb_result_streamer;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  result_streamer_if #(.MAT_W(64)) bus ();

  result_streamer #(
    .HDR_BYTE(8'h02),
    .ELEM_W  (16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  localparam logic [63:0] MAT_A   = 64'h0001_0002_0003_0004;
  localparam logic [79:0] BEATS_A = 80'h02_00_01_00_02_00_03_00_04_04;
  localparam logic [63:0] MAT_B   = 64'h1122_3344_5566_7788;
  localparam logic [79:0] BEATS_B = 80'h02_11_22_33_44_55_66_77_88_88;
  localparam logic [63:0] MAT_C   = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] MAT_D   = 64'hDEAD_BEEF_0102_0304;
  localparam logic [79:0] BEATS_D = 80'h02_DE_AD_BE_EF_01_02_03_04_26;

  logic [9:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: condition not met at %0t", name, $time);
  endtask

  task automatic push_beats(input logic [79:0] beats);
    for (int i = 0; i < 10; i++) begin
      logic [1:0] ctrl;
      ctrl = (i == 0) ? 2'd2 : ((i == 9) ? 2'd1 : 2'd0);
      exp_q.push_back({ctrl, beats[79-8*i -: 8]});
    end
  endtask

  task automatic push_model(input logic [63:0] mat);
    logic [79:0] beats;
    logic [7:0]  cs;
    cs = 8'h00;
    beats[79:72] = 8'h02;
    for (int k = 0; k < 8; k++) begin
      beats[71-8*k -: 8] = mat[63-8*k -: 8];
      cs = cs ^ mat[63-8*k -: 8];
    end
    beats[7:0] = cs;
    push_beats(beats);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_stimulus(input logic [63:0] mat, input logic [79:0] beats, input bit expect_frame);
    if (expect_frame) push_beats(beats);
    bus.res_mat   = mat;
    bus.res_valid = 1'b1;
    step();
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input bit toggle, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
      if (toggle) bus.out_ready = !bus.out_ready;
    end while (bus.busy && cycles < limit);
    if (bus.busy) note_fail("idle_timeout");
    bus.out_ready = 1'b1;
  endtask

  // Transfers happen at the next posedge, so negedge values describe the pending beat.
  always @(negedge CLK) begin
    if (!RST && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        note_fail("unexpected_beat");
      end else if (bus.out_ready) begin
        check_output("beat", 16'({bus.ctrl_out, bus.data_out}), 16'(exp_q[0]));
        void'(exp_q.pop_front());
      end else begin
        check_output("stall_beat", 16'({bus.ctrl_out, bus.data_out}), 16'(exp_q[0]));
      end
    end
  end

  initial begin
    int cyc;

    RST           = 1'b1;
    bus.res_valid = 1'b0;
    bus.res_mat   = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    check_output("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check_output("rst_busy", 16'(bus.busy), 16'd0);
    check_output("rst_data_out", 16'(bus.data_out), 16'd0);
    check_output("rst_ctrl_out", 16'(bus.ctrl_out), 16'd0);
    check_output("rst_overflow", 16'(bus.overflow), 16'd0);
    check_output("rst_frame_cnt", 16'(bus.frame_cnt), 16'd0);
    RST = 1'b0;
    step();

    $display("[TB] single frame, out_ready held high");
    apply_stimulus(MAT_A, BEATS_A, 1'b1);
    check_output("hdr_latency_valid", 16'(bus.out_valid), 16'd1);
    check_output("hdr_latency_ctrl", 16'(bus.ctrl_out), 16'd2);
    wait_idle(40, 1'b0, cyc);
    check_output("frame_cycles", 16'(cyc), 16'd10);
    exp_frames++;
    check_output("frame_cnt_1", 16'(bus.frame_cnt), 16'(exp_frames));

    $display("[TB] single frame, out_ready toggling");
    apply_stimulus(MAT_A, BEATS_A, 1'b1);
    wait_idle(60, 1'b1, cyc);
    check_output("stalled_frame_cycles", 16'(cyc), 16'd19);
    exp_frames++;
    check_output("frame_cnt_2", 16'(bus.frame_cnt), 16'(exp_frames));

    $display("[TB] three results during one frame");
    apply_stimulus(MAT_A, BEATS_A, 1'b1);
    apply_stimulus(MAT_B, BEATS_B, 1'b1);
    apply_stimulus(MAT_C, BEATS_A, 1'b0);
    check_output("overflow_set", 16'(bus.overflow), 16'd1);
    wait_idle(60, 1'b0, cyc);
    check_output("back_to_back_cycles", 16'(cyc), 16'd18);
    exp_frames += 2;
    check_output("frame_cnt_4", 16'(bus.frame_cnt), 16'(exp_frames));
    check_output("overflow_sticky", 16'(bus.overflow), 16'd1);

    $display("[TB] result arriving on the checksum transfer");
    apply_stimulus(MAT_A, BEATS_A, 1'b1);
    for (int i = 0; i < 9; i++) step();
    check_output("csum_cycle_ctrl", 16'(bus.ctrl_out), 16'd1);
    apply_stimulus(MAT_D, BEATS_D, 1'b1);
    check_output("chain_busy", 16'(bus.busy), 16'd1);
    check_output("chain_hdr_valid", 16'(bus.out_valid), 16'd1);
    check_output("chain_hdr_ctrl", 16'(bus.ctrl_out), 16'd2);
    wait_idle(40, 1'b0, cyc);
    check_output("chain_frame_cycles", 16'(cyc), 16'd10);
    exp_frames += 2;
    check_output("frame_cnt_6", 16'(bus.frame_cnt), 16'(exp_frames));

    $display("[TB] reset during payload byte 4");
    apply_stimulus(MAT_A, BEATS_A, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check_output("abort_point_ctrl", 16'(bus.ctrl_out), 16'd0);
    RST           = 1'b1;
    bus.res_mat   = MAT_B;
    bus.res_valid = 1'b1;
    step();
    bus.res_valid = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    check_output("abort_out_valid", 16'(bus.out_valid), 16'd0);
    check_output("abort_busy", 16'(bus.busy), 16'd0);
    check_output("abort_frame_cnt", 16'(bus.frame_cnt), 16'd0);
    check_output("abort_overflow", 16'(bus.overflow), 16'd0);
    RST = 1'b0;
    step();
    check_output("reset_pulse_ignored", 16'(bus.busy), 16'd0);
    apply_stimulus(MAT_A, BEATS_A, 1'b1);
    wait_idle(40, 1'b0, cyc);
    exp_frames++;
    check_output("post_reset_frame_cnt", 16'(bus.frame_cnt), 16'(exp_frames));

    $display("[TB] 256 frames for counter wrap");
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      logic [63:0] mat;
      mat = {16'(i), 16'(i * 3), 16'(i ^ 16'h5A5A), 16'(255 - i)};
      push_model(mat);
      apply_stimulus(mat, BEATS_A, 1'b0);
      wait_idle(40, 1'b0, cyc);
      check_output("wrap_frame_cycles", 16'(cyc), 16'd10);
      if (i == 254) check_output("frame_cnt_255", 16'(bus.frame_cnt), 16'd255);
    end
    check_output("frame_cnt_wrap", 16'(bus.frame_cnt), 16'd0);

    step();
    check_output("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
